board_eval: RTL and testbench
=============================

Name: board_eval

Overview:
- Downstream consumer of the pawn move generator and its sibling move generators.
- Reads a contiguous run of generated successor boards from SDRAM, computes a signed material score for each board, and reports the index and score of the best board to the CPU.
- Same dual Avalon-MM shape as the generators: CPU-facing slave for configuration and results, SDRAM-facing master for board reads. Board layout: 64 words per board, square (x,y) at word y*8+x, piece in bits [7:0] as signed 8-bit (0 empty, +white, -black).

Parameters:
- BOARD_WORDS, 64, words per board; the board stride is BOARD_WORDS*4 bytes.
- MAX_BOARDS, 255, largest accepted board count; larger counts are clamped to this value.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- slave_waitrequest  out  1  CPU slave stall
- slave_address  in  4  CPU register select
- slave_read  in  1  CPU read strobe
- slave_readdata  out  32  CPU read data
- slave_write  in  1  CPU write strobe
- slave_writedata  in  32  CPU write data
- master_waitrequest  in  1  SDRAM stall
- master_address  out  32  SDRAM byte address
- master_read  out  1  SDRAM read strobe
- master_readdata  in  32  SDRAM read data
- master_readdatavalid  in  1  SDRAM read data valid
- master_write  out  1  tied 0; the block never writes
- master_writedata  out  32  tied 0

Behaviour:
- Reset is clk/rst_n synchronous active-low. Reset values:
  - state IDLE, slave_waitrequest 0, slave_readdata 0, master_read 0, master_address 0.
  - base 0, count 0, maximize 1, best_idx 0xFFFFFFFF, best_score 0x80000000, done 0.
- Slave register map. slave_waitrequest is always 0; single-cycle accept.
  - Write 1: base byte address.
  - Write 2: board count. Values above MAX_BOARDS are clamped to MAX_BOARDS.
  - Write 3: maximize flag, bit 0. 1 selects the maximum score (white to move); 0 selects the minimum.
  - Write 0: start. Accepted only in IDLE or DONE. On accept: clear done, best_idx := 0xFFFFFFFF, best_score := 0x80000000 if maximize else 0x7FFFFFFF, board := 0, square := 0.
  - Writes to 1..3 while busy are ignored. A write to 0 while busy is ignored.
  - Read 0 returns {31'b0, done}. Read 1 returns best_idx. Read 2 returns best_score.
  - slave_readdata is registered: it is valid the cycle after slave_read.
- States:
  - IDLE: start -> CLR_ACC.
  - CLR_ACC: acc := 0. If board == count -> DONE, else -> RD.
  - RD: master_read = 1. master_address = base + board*BOARD_WORDS*4 + square*4. Hold all master outputs while master_waitrequest is 1. When master_waitrequest is 0 -> WAIT_DATA.
  - WAIT_DATA: on master_readdatavalid, acc := acc + value(readdata[7:0]).
    - If square == 63 -> CMP.
    - Otherwise square++ -> RD.
  - CMP: update best if (maximize and acc > best_score) or (!maximize and acc < best_score). The update is best_score := acc, best_idx := board. Then board++, square := 0 -> CLR_ACC.
  - DONE: done = 1. A start write -> CLR_ACC with the re-initialisation above.
- Only one read is ever outstanding. No new read is issued until readdatavalid returns.
- Piece values use the magnitude of the signed piece code:
  - 1 pawn = 100, 2 knight = 320, 3 bishop = 330, 4 rook = 500, 5 queen = 900, 6 king = 20000.
  - 0, or a magnitude of 7 or more, = 0.
  - Sign follows the piece: white adds, black subtracts.
- Arithmetic: acc and best_score are signed 32-bit. The maximum absolute sum is well below 2^31, so no overflow can occur.
- Ties: the comparison is strict, so the earliest board wins.
- count == 0: the block goes straight from CLR_ACC to DONE. done = 1, best_idx stays 0xFFFFFFFF, best_score keeps its sentinel.
- Latency per board: 64 × (RD cycles + WAIT_DATA cycles) + 2 cycles. With zero-wait SDRAM and 1-cycle valid, that is 130 cycles per board.
- Reset mid-operation: state returns to IDLE immediately and master_read drops to 0 in the same cycle reset is sampled. A late readdatavalid after reset is ignored.
- readdatavalid outside WAIT_DATA is ignored.

Decomposition:
- Shared package chess_pkg holds:
  - EMPTY = 0 and the piece code constants PAWN..KING = 1..6.
  - BOARD_WORDS.
  - The piece value constants.
  - A function piece_value(signed [7:0]) returning signed [31:0].
- The move generators should migrate their EMPTY define to this package.
- One natural sub-module: piece_scorer, a combinational lookup from piece code to signed value. It is instantiated once in board_eval and is reusable by future evaluators.

Test Plan:
- Single board, starting position, base = 0x1000, count = 1, maximize = 1, start:
  - Expect exactly 64 reads at addresses 0x1000..0x10FC in order.
  - Expect read 1 = 0 and read 2 = 0.
- Three boards, identical except board 1 lacks a black pawn and board 2 lacks a black queen, count = 3, maximize = 1:
  - Expect best_idx = 2, best_score = 900.
  - Rerun with maximize = 0: expect best_idx = 0, score = 0.
- Tie: boards 0 and 1 both score +100, maximize = 1 -> best_idx = 0 (strict compare).
- count = 0, start:
  - done = 1 within 2 cycles, no master_read asserted.
  - read 1 = 0xFFFFFFFF, read 2 = 0x80000000.
- Random SDRAM stalls: master_waitrequest high 0–5 cycles and readdatavalid delayed 1–4 cycles.
  - master_address and master_read stay stable while stalled.
  - Results match the zero-wait run.
- Reset asserted mid-board 1 of 3:
  - master_read = 0 the next cycle, done = 0, read 1 = 0xFFFFFFFF.
  - A fresh start with count = 1 produces the correct result.

Source files
------------

// File: rtl/chess_pkg.sv
// Shared chess definitions: piece codes, board geometry and material values.
// Used by the move generators and board evaluators.
package chess_pkg;

  localparam int BOARD_WORDS = 64;

  localparam logic [7:0] EMPTY  = 8'd0;
  localparam logic [7:0] PAWN   = 8'd1;
  localparam logic [7:0] KNIGHT = 8'd2;
  localparam logic [7:0] BISHOP = 8'd3;
  localparam logic [7:0] ROOK   = 8'd4;
  localparam logic [7:0] QUEEN  = 8'd5;
  localparam logic [7:0] KING   = 8'd6;

  localparam logic signed [31:0] PAWN_VALUE   = 32'sd100;
  localparam logic signed [31:0] KNIGHT_VALUE = 32'sd320;
  localparam logic signed [31:0] BISHOP_VALUE = 32'sd330;
  localparam logic signed [31:0] ROOK_VALUE   = 32'sd500;
  localparam logic signed [31:0] QUEEN_VALUE  = 32'sd900;
  localparam logic signed [31:0] KING_VALUE   = 32'sd20000;

  localparam logic [3:0] REG_START      = 4'd0;
  localparam logic [3:0] REG_BASE       = 4'd1;
  localparam logic [3:0] REG_COUNT      = 4'd2;
  localparam logic [3:0] REG_MAXIMIZE   = 4'd3;
  localparam logic [3:0] REG_STATUS     = 4'd0;
  localparam logic [3:0] REG_BEST_IDX   = 4'd1;
  localparam logic [3:0] REG_BEST_SCORE = 4'd2;

  localparam logic [31:0]        BEST_IDX_NONE = 32'hFFFF_FFFF;
  localparam logic signed [31:0] SCORE_FLOOR   = 32'sh8000_0000;
  localparam logic signed [31:0] SCORE_CEIL    = 32'sh7FFF_FFFF;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLR_ACC,
    ST_RD,
    ST_WAIT_DATA,
    ST_CMP,
    ST_DONE
  } eval_state_t;

  // Magnitude picks the piece, sign picks the side; -128 has magnitude 128 and scores 0.
  function automatic logic signed [31:0] piece_value(input logic signed [7:0] code);
    logic [7:0]        mag;
    logic signed [31:0] v;
    mag = code[7] ? 8'(-code) : code;
    case (mag)
      PAWN:    v = PAWN_VALUE;
      KNIGHT:  v = KNIGHT_VALUE;
      BISHOP:  v = BISHOP_VALUE;
      ROOK:    v = ROOK_VALUE;
      QUEEN:   v = QUEEN_VALUE;
      KING:    v = KING_VALUE;
      default: v = 32'sd0;
    endcase
    return code[7] ? -v : v;
  endfunction

endpackage

// File: rtl/piece_scorer.sv
// Combinational lookup from a signed piece code to its signed material value.
module piece_scorer
  import chess_pkg::*;
(
  input  logic [7:0]         i_piece,
  output logic signed [31:0] o_value
);

  assign o_value = piece_value(i_piece);

endmodule

// File: rtl/board_eval.sv
// Scores a run of boards in SDRAM by material and reports the best board to the CPU.
// One SDRAM read outstanding at a time; the CPU slave never stalls.
module board_eval
  import chess_pkg::*;
#(
  parameter int MAX_BOARDS = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        slave_waitrequest,
  input  logic [3:0]  slave_address,
  input  logic        slave_read,
  output logic [31:0] slave_readdata,
  input  logic        slave_write,
  input  logic [31:0] slave_writedata,
  input  logic        master_waitrequest,
  output logic [31:0] master_address,
  output logic        master_read,
  input  logic [31:0] master_readdata,
  input  logic        master_readdatavalid,
  output logic        master_write,
  output logic [31:0] master_writedata
);

  localparam int CW   = $clog2(MAX_BOARDS + 1);
  localparam int SQ_W = $clog2(BOARD_WORDS);
  localparam logic [SQ_W-1:0] LAST_SQ = SQ_W'(BOARD_WORDS - 1);

  // Handshake: a read is accepted on any clock edge where master_read is high and
  // master_waitrequest is low; its data returns later on a master_readdatavalid pulse.

  eval_state_t r_state, w_state_next;

  logic [31:0]        r_base;
  logic [CW-1:0]      r_count;
  logic               r_maximize;
  logic [31:0]        r_best_idx;
  logic signed [31:0] r_best_score;
  logic               r_done;
  logic [CW-1:0]      r_board;
  logic [SQ_W-1:0]    r_square;
  logic signed [31:0] r_acc;
  logic [31:0]        r_readdata;

  logic               w_busy;
  logic               w_start;
  logic [CW-1:0]      w_count_clamped;
  logic signed [31:0] w_piece_value;
  logic               w_better;
  logic [31:0]        w_rd_addr;
  logic               w_unused_rdata;

  assign w_busy  = !(r_state == ST_IDLE || r_state == ST_DONE);
  assign w_start = slave_write && (slave_address == REG_START) && !w_busy;
  assign w_count_clamped = (slave_writedata > 32'(MAX_BOARDS)) ? CW'(MAX_BOARDS)
                                                                 : slave_writedata[CW-1:0];
  assign w_better = r_maximize ? (r_acc > r_best_score) : (r_acc < r_best_score);
  assign w_rd_addr = r_base + 32'(r_board) * 32'(BOARD_WORDS * 4)
                   + {{(30 - SQ_W){1'b0}}, r_square, 2'b00};
  assign w_unused_rdata = ^master_readdata[31:8];

  piece_scorer u_piece_scorer (
    .i_piece (master_readdata[7:0]),
    .o_value (w_piece_value)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE, ST_DONE: if (w_start) w_state_next = ST_CLR_ACC;
      ST_CLR_ACC:       w_state_next = (r_board == r_count) ? ST_DONE : ST_RD;
      ST_RD:            if (!master_waitrequest) w_state_next = ST_WAIT_DATA;
      ST_WAIT_DATA: begin
        if (master_readdatavalid) w_state_next = (r_square == LAST_SQ) ? ST_CMP : ST_RD;
      end
      ST_CMP:           w_state_next = ST_CLR_ACC;
      default:          w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_base       <= '0;
      r_count      <= '0;
      r_maximize   <= 1'b1;
      r_best_idx   <= BEST_IDX_NONE;
      r_best_score <= SCORE_FLOOR;
      r_done       <= 1'b0;
      r_board      <= '0;
      r_square     <= '0;
      r_acc        <= '0;
      r_readdata   <= '0;
    end else begin
      if (slave_write && !w_busy) begin
        case (slave_address)
          REG_BASE:     r_base     <= slave_writedata;
          REG_COUNT:    r_count    <= w_count_clamped;
          REG_MAXIMIZE: r_maximize <= slave_writedata[0];
          default: ;
        endcase
      end

      if (w_start) begin
        r_done       <= 1'b0;
        r_best_idx   <= BEST_IDX_NONE;
        r_best_score <= r_maximize ? SCORE_FLOOR : SCORE_CEIL;
        r_board      <= '0;
        r_square     <= '0;
      end

      case (r_state)
        ST_CLR_ACC: begin
          r_acc <= '0;
          if (r_board == r_count) r_done <= 1'b1;
        end
        ST_WAIT_DATA: begin
          if (master_readdatavalid) begin
            r_acc <= r_acc + w_piece_value;
            if (r_square != LAST_SQ) r_square <= r_square + 1'b1;
          end
        end
        ST_CMP: begin
          // Strict compare keeps the earliest board on ties.
          if (w_better) begin
            r_best_score <= r_acc;
            r_best_idx   <= 32'(r_board);
          end
          r_board  <= r_board + 1'b1;
          r_square <= '0;
        end
        default: ;
      endcase

      if (slave_read) begin
        case (slave_address)
          REG_STATUS:     r_readdata <= {31'b0, r_done};
          REG_BEST_IDX:   r_readdata <= r_best_idx;
          REG_BEST_SCORE: r_readdata <= r_best_score;
          default:        r_readdata <= '0;
        endcase
      end
    end
  end

  assign slave_waitrequest = 1'b0;
  assign slave_readdata    = r_readdata;
  assign master_read       = (r_state == ST_RD);
  assign master_address    = (r_state == ST_RD) ? w_rd_addr : 32'd0;
  assign master_write      = 1'b0;
  assign master_writedata  = 32'd0;

endmodule

// File: tb/tb_board_eval.sv
// Randomized bench for board_eval: SDRAM responder with optional stalls and a
// material-score reference model computed directly from the board contents.
module tb_board_eval;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        s_wait;
  logic [3:0]  s_addr;
  logic        s_read;
  logic [31:0] s_rdata;
  logic        s_write;
  logic [31:0] s_wdata;
  logic        m_wait;
  logic [31:0] m_addr;
  logic        m_read;
  logic [31:0] m_rdata;
  logic        m_valid;
  logic        m_write;
  logic [31:0] m_wdata;

  always #5 clk = ~clk;

  board_eval dut (
    .clk                  (clk),
    .rst_n                (rst_n),
    .slave_waitrequest    (s_wait),
    .slave_address        (s_addr),
    .slave_read           (s_read),
    .slave_readdata       (s_rdata),
    .slave_write          (s_write),
    .slave_writedata      (s_wdata),
    .master_waitrequest   (m_wait),
    .master_address       (m_addr),
    .master_read          (m_read),
    .master_readdata      (m_rdata),
    .master_readdatavalid (m_valid),
    .master_write         (m_write),
    .master_writedata     (m_wdata)
  );

  int vectors = 0;
  int miscompares = 0;

  logic signed [7:0] bd [0:255][0:63];
  logic [31:0] cur_base = 32'h0;
  logic [31:0] addr_q[$];

  bit          stall_mode = 1'b0;
  bit          in_req = 1'b0;
  bit          accepting = 1'b0;
  int          stall_left = 0;
  int          pend_cnt = 0;
  logic [31:0] held_addr;
  logic [31:0] acc_addr;
  logic [31:0] pend_data;
  int          stall_viol = 0;
  int          stall_cycles = 0;
  int          read_seen = 0;

  // ---------------- reference model ----------------
  function automatic int piece_val(input int code);
    int m;
    int v;
    m = (code < 0) ? -code : code;
    case (m)
      1: v = 100;
      2: v = 320;
      3: v = 330;
      4: v = 500;
      5: v = 900;
      6: v = 20000;
      default: v = 0;
    endcase
    return (code < 0) ? -v : v;
  endfunction

  function automatic int board_score(input int b);
    int s;
    s = 0;
    for (int q = 0; q < 64; q++) s += piece_val(int'(bd[b][q]));
    return s;
  endfunction

  task automatic model_best(input int n, input bit mx,
                            output logic [31:0] idx, output logic [31:0] sc);
    int scores[$];
    int target;
    idx = 32'hFFFF_FFFF;
    sc  = mx ? 32'h8000_0000 : 32'h7FFF_FFFF;
    if (n > 255) n = 255;
    for (int b = 0; b < n; b++) scores.push_back(board_score(b));
    if (n == 0) return;
    target = scores[0];
    foreach (scores[i]) if (mx ? (scores[i] > target) : (scores[i] < target)) target = scores[i];
    foreach (scores[i]) begin
      if (scores[i] == target) begin
        idx = 32'(i);
        sc  = target;
        break;
      end
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [31:0] idx;
    logic [31:0] r;
    idx = (a - cur_base) >> 2;
    r = $urandom;
    if (idx >= 32'd16384) return {r[31:8], 8'h00};
    return {r[31:8], bd[idx / 64][idx % 64]};
  endfunction

  // ---------------- SDRAM responder ----------------
  initial begin
    m_wait = 1'b0; m_valid = 1'b0; m_rdata = 32'h0;
    forever begin
      @(negedge clk);
      m_valid = 1'b0;
      if (accepting) begin
        accepting = 1'b0;
        addr_q.push_back(acc_addr);
        pend_data = mem_word(acc_addr);
        pend_cnt  = stall_mode ? $urandom_range(1, 4) : 1;
      end
      if (pend_cnt > 0) begin
        pend_cnt--;
        if (pend_cnt == 0) begin
          m_valid = 1'b1;
          m_rdata = pend_data;
        end
      end
      m_wait = 1'b0;
      if (m_read === 1'b1) begin
        read_seen++;
        if (!in_req) begin
          in_req     = 1'b1;
          held_addr  = m_addr;
          stall_left = stall_mode ? $urandom_range(0, 5) : 0;
        end else if (m_addr !== held_addr) begin
          stall_viol++;
        end
        if (stall_left > 0) begin
          m_wait = 1'b1;
          stall_left--;
          stall_cycles++;
        end else begin
          accepting = 1'b1;
          acc_addr  = held_addr;
          in_req    = 1'b0;
        end
      end else begin
        if (in_req) stall_viol++;
        in_req = 1'b0;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_write(input logic [3:0] a, input logic [31:0] d);
    @(negedge clk);
    s_write = 1'b1; s_addr = a; s_wdata = d;
    @(negedge clk);
    s_write = 1'b0;
  endtask

  task automatic do_read(input logic [3:0] a, output logic [31:0] d);
    @(negedge clk);
    s_read = 1'b1; s_addr = a;
    @(negedge clk);
    s_read = 1'b0;
    d = s_rdata;
  endtask

  task automatic run(input logic [31:0] base, input int n, input bit mx,
                     output logic [31:0] idx, output logic [31:0] sc, output bit ok);
    logic [31:0] d;
    int limit;
    cur_base = base;
    do_write(4'd1, base);
    do_write(4'd2, 32'(n));
    do_write(4'd3, {31'b0, mx});
    do_write(4'd0, 32'd1);
    ok = 1'b0;
    limit = ((n > 255) ? 255 : n) * 64 * 12 + 200;
    for (int c = 0; c < limit; c++) begin
      do_read(4'd0, d);
      if (d[0]) begin
        ok = 1'b1;
        break;
      end
    end
    do_read(4'd1, idx);
    do_read(4'd2, sc);
  endtask

  task automatic load_start(input int b);
    logic signed [7:0] back [0:7];
    back = '{8'sd4, 8'sd2, 8'sd3, 8'sd5, 8'sd6, 8'sd3, 8'sd2, 8'sd4};
    for (int q = 0; q < 64; q++) bd[b][q] = 8'sd0;
    for (int x = 0; x < 8; x++) begin
      bd[b][x]      = back[x];
      bd[b][8 + x]  = 8'sd1;
      bd[b][48 + x] = -8'sd1;
      bd[b][56 + x] = -back[x];
    end
  endtask

  task automatic load_random(input int b);
    int r;
    int mag;
    logic [31:0] rr;
    for (int q = 0; q < 64; q++) begin
      r = $urandom_range(0, 9);
      if (r < 5) bd[b][q] = 8'sd0;
      else if (r < 9) begin
        mag = $urandom_range(1, 6);
        bd[b][q] = ($urandom_range(0, 1) == 1) ? 8'(-mag) : 8'(mag);
      end else begin
        rr = $urandom;
        bd[b][q] = rr[7:0];
      end
    end
  endtask

  task automatic check_result(input string name, input logic [31:0] idx, input logic [31:0] sc,
                              input bit ok, input logic [31:0] e_idx, input logic [31:0] e_sc);
    vectors++;
    if (!ok) begin
      miscompares++;
      $display("FAIL %s done: timeout waiting for done", name);
    end
    vectors++;
    if (idx !== e_idx) begin
      miscompares++;
      $display("FAIL %s best_idx: got %0h expected %0h", name, idx, e_idx);
    end
    vectors++;
    if (sc !== e_sc) begin
      miscompares++;
      $display("FAIL %s best_score: got %0h expected %0h", name, sc, e_sc);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [31:0] d;
    vectors++;
    if (m_read !== 1'b0 || m_addr !== 32'h0) begin
      miscompares++;
      $display("FAIL reset master: read=%b addr=%0h expected 0/0", m_read, m_addr);
    end
    vectors++;
    if (s_wait !== 1'b0 || m_write !== 1'b0 || m_wdata !== 32'h0) begin
      miscompares++;
      $display("FAIL reset ties: wait=%b write=%b wdata=%0h expected zeros", s_wait, m_write, m_wdata);
    end
    vectors++;
    if (s_rdata !== 32'h0) begin
      miscompares++;
      $display("FAIL reset readdata: got %0h expected 0", s_rdata);
    end
    do_read(4'd0, d);
    vectors++;
    if (d !== 32'h0) begin miscompares++; $display("FAIL reset done: got %0h expected 0", d); end
    do_read(4'd1, d);
    vectors++;
    if (d !== 32'hFFFF_FFFF) begin miscompares++; $display("FAIL reset best_idx: got %0h expected ffffffff", d); end
    do_read(4'd2, d);
    vectors++;
    if (d !== 32'h8000_0000) begin miscompares++; $display("FAIL reset best_score: got %0h expected 80000000", d); end
  endtask

  task automatic test_start_position();
    logic [31:0] idx, sc, e_idx, e_sc;
    bit ok;
    load_start(0);
    addr_q.delete();
    run(32'h1000, 1, 1'b1, idx, sc, ok);
    model_best(1, 1'b1, e_idx, e_sc);
    check_result("start_pos", idx, sc, ok, e_idx, e_sc);
    vectors++;
    if (addr_q.size() != 64) begin
      miscompares++;
      $display("FAIL start_pos read_count: got %0d expected 64", addr_q.size());
    end
    for (int i = 0; i < 64 && i < addr_q.size(); i++) begin
      vectors++;
      if (addr_q[i] !== 32'h1000 + 32'(4 * i)) begin
        miscompares++;
        $display("FAIL start_pos addr[%0d]: got %0h expected %0h", i, addr_q[i], 32'h1000 + 32'(4 * i));
      end
    end
  endtask

  task automatic test_three_boards();
    logic [31:0] idx, sc, e_idx, e_sc;
    bit ok;
    load_start(0);
    load_start(1); bd[1][48] = 8'sd0;
    load_start(2); bd[2][59] = 8'sd0;
    run(32'h0002_0000, 3, 1'b1, idx, sc, ok);
    model_best(3, 1'b1, e_idx, e_sc);
    check_result("three_max", idx, sc, ok, e_idx, e_sc);
    run(32'h0002_0000, 3, 1'b0, idx, sc, ok);
    model_best(3, 1'b0, e_idx, e_sc);
    check_result("three_min", idx, sc, ok, e_idx, e_sc);
  endtask

  task automatic test_tie();
    logic [31:0] idx, sc, e_idx, e_sc;
    bit ok;
    load_start(0); bd[0][50] = 8'sd0;
    load_start(1); bd[1][53] = 8'sd0;
    load_start(2);
    run(32'h0000_4000, 3, 1'b1, idx, sc, ok);
    model_best(3, 1'b1, e_idx, e_sc);
    check_result("tie", idx, sc, ok, e_idx, e_sc);
  endtask

  task automatic test_count_zero();
    logic [31:0] d;
    int seen_before;
    bit got_done;
    do_write(4'd2, 32'd0);
    do_write(4'd3, 32'd1);
    seen_before = read_seen;
    do_write(4'd0, 32'd1);
    got_done = 1'b0;
    // Status read is registered, so the third poll covers done within 2 cycles.
    for (int c = 0; c < 3; c++) begin
      do_read(4'd0, d);
      if (d[0]) begin got_done = 1'b1; break; end
    end
    vectors++;
    if (!got_done) begin miscompares++; $display("FAIL zero_count done: got 0 expected 1"); end
    vectors++;
    if (read_seen != seen_before) begin
      miscompares++;
      $display("FAIL zero_count master_read: got %0d reads expected 0", read_seen - seen_before);
    end
    do_read(4'd1, d);
    vectors++;
    if (d !== 32'hFFFF_FFFF) begin miscompares++; $display("FAIL zero_count best_idx: got %0h expected ffffffff", d); end
    do_read(4'd2, d);
    vectors++;
    if (d !== 32'h8000_0000) begin miscompares++; $display("FAIL zero_count best_score: got %0h expected 80000000", d); end
  endtask

  task automatic test_random_stalls();
    logic [31:0] idx, sc, idx0, sc0, e_idx, e_sc;
    bit ok, mx;
    int n;
    for (int it = 0; it < 3; it++) begin
      n  = $urandom_range(2, 5);
      mx = 1'($urandom_range(0, 1));
      for (int b = 0; b < n; b++) load_random(b);
      model_best(n, mx, e_idx, e_sc);
      stall_mode = 1'b0;
      run(32'h0010_0000, n, mx, idx0, sc0, ok);
      check_result("rand_nowait", idx0, sc0, ok, e_idx, e_sc);
      stall_mode   = 1'b1;
      stall_viol   = 0;
      stall_cycles = 0;
      run(32'h0010_0000, n, mx, idx, sc, ok);
      stall_mode = 1'b0;
      check_result("rand_stall", idx, sc, ok, e_idx, e_sc);
      vectors++;
      if (stall_viol != 0) begin
        miscompares++;
        $display("FAIL rand_stall stability: got %0d changes expected 0", stall_viol);
      end
      vectors++;
      if (stall_cycles == 0) begin
        miscompares++;
        $display("FAIL rand_stall coverage: got 0 stall cycles expected >0");
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] d, idx, sc, e_idx, e_sc;
    bit ok, reached;
    for (int b = 0; b < 3; b++) load_random(b);
    stall_mode = 1'b1;
    addr_q.delete();
    cur_base = 32'h0000_8000;
    do_write(4'd1, cur_base);
    do_write(4'd2, 32'd3);
    do_write(4'd3, 32'd1);
    do_write(4'd0, 32'd1);
    reached = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if (addr_q.size() > 80 && m_read === 1'b1) begin reached = 1'b1; break; end
    end
    vectors++;
    if (!reached) begin miscompares++; $display("FAIL reset_mid reach: board 1 read not seen"); end
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    vectors++;
    if (m_read !== 1'b0) begin miscompares++; $display("FAIL reset_mid master_read: got %b expected 0", m_read); end
    do_read(4'd0, d);
    vectors++;
    if (d !== 32'h0) begin miscompares++; $display("FAIL reset_mid done: got %0h expected 0", d); end
    do_read(4'd1, d);
    vectors++;
    if (d !== 32'hFFFF_FFFF) begin miscompares++; $display("FAIL reset_mid best_idx: got %0h expected ffffffff", d); end
    repeat (8) @(negedge clk);
    stall_mode = 1'b0;
    load_random(0);
    model_best(1, 1'b1, e_idx, e_sc);
    run(32'h0000_C000, 1, 1'b1, idx, sc, ok);
    check_result("reset_mid_rerun", idx, sc, ok, e_idx, e_sc);
  endtask

  task automatic test_clamp();
    logic [31:0] idx, sc, e_idx, e_sc;
    bit ok;
    for (int b = 0; b < 256; b++) load_random(b);
    bd[255][4] = 8'sd6; bd[255][60] = 8'sd0;
    model_best(300, 1'b1, e_idx, e_sc);
    addr_q.delete();
    run(32'h0100_0000, 300, 1'b1, idx, sc, ok);
    check_result("clamp", idx, sc, ok, e_idx, e_sc);
    vectors++;
    if (addr_q.size() != 255 * 64) begin
      miscompares++;
      $display("FAIL clamp read_count: got %0d expected %0d", addr_q.size(), 255 * 64);
    end
  endtask

  initial begin
    rst_n = 1'b0; s_addr = 4'd0; s_read = 1'b0; s_write = 1'b0; s_wdata = 32'h0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    test_reset();
    test_start_position();
    test_three_boards();
    test_tie();
    test_count_zero();
    test_random_stalls();
    test_reset_mid();
    test_clamp();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
